// File: rtl/pcm_fetch_pkg.sv
// rtl/pcm_fetch_pkg.sv - shared state enum, word geometry and byte-lane helper for the PCM ROM fetcher
package pcm_fetch_pkg;

    localparam int WORD_BYTES = 8;
    localparam int OFFSET_W   = 3;

    typedef enum logic [2:0] {
        IDLE,
        HIT,
        ISSUE,
        WAIT,
        DELIVER
    } fetch_state_t;

    // Byte k of a 64-bit word lives in bits [8k+7:8k].
    function automatic logic [7:0] word_byte(input logic [63:0] word, input logic [OFFSET_W-1:0] off);
        return word[{off, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/pcm_rr_arb.sv
// rtl/pcm_rr_arb.sv - round-robin arbiter, one-hot grant, pointer advances past the winner on accept
module pcm_rr_arb #(
    parameter int N = 2
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] next_ptr;
    logic [PTR_W-1:0] pos;
    logic             found;

    // Scan from the pointer upward and take the first pending requester.
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        pos      = '0;
        for (int i = 0; i < N; i++) begin
            pos = PTR_W'((int'(ptr) + i) % N);
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                next_ptr   = PTR_W'((int'(pos) + 1) % N);
            end
        end
    end

    // Priority pointer: channel 0 first after reset, then the one after the last winner.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= next_ptr;
        end
    end

endmodule

// File: rtl/pcm_rom_fetch.sv
// rtl/pcm_rom_fetch.sv - PCM ROM byte fetcher over a 64-bit DDRAM port; line cache with PCM_FETCH_CACHE_EN
module pcm_rom_fetch
    import pcm_fetch_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 18
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH-1:0]        ch_read,
    output logic [NUM_CH*8-1:0]      ch_data,
    output logic [NUM_CH-1:0]        ch_rdy,
    output logic [ADDR_W-4:0]        mem_addr,
    output logic                     mem_req,
    input  logic                     mem_rdy,
    input  logic [63:0]              mem_dout
);

    localparam int TAG_W = ADDR_W - OFFSET_W;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    fetch_state_t          state;
    fetch_state_t          state_nx;
    logic [NUM_CH-1:0]     grant;
    logic [CH_W-1:0]       grant_idx;
    logic [CH_W-1:0]       cur_ch;
    logic [ADDR_W-1:0]     grant_addr;
    logic [OFFSET_W-1:0]   cur_off;
    logic                  any_req;
    logic                  accept;
    logic                  grant_hit;
    logic [7:0]            hit_byte;
    logic                  drop_seen;
    logic                  deliver_ok;

    assign any_req    = |ch_read;
    assign accept     = (state == IDLE) && any_req;
    assign grant_addr = ch_addr[int'(grant_idx)*ADDR_W +: ADDR_W];

    pcm_rr_arb #(.N(NUM_CH)) u_arb (
        .clk_sys (clk_sys),
        .reset   (reset),
        .req     (ch_read),
        .accept  (accept),
        .grant   (grant)
    );

    // One-hot grant to channel index.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) grant_idx = CH_W'(i);
        end
    end

`ifdef PCM_FETCH_CACHE_EN
    logic [63:0]      line_data [NUM_CH];
    logic [TAG_W-1:0] line_tag  [NUM_CH];
    logic [NUM_CH-1:0] line_valid;
    logic             flush_seen;

    // A flush in the grant cycle must not let a soon-to-be-stale line answer.
    assign grant_hit = line_valid[grant_idx] && !flush
                       && (line_tag[grant_idx] == grant_addr[ADDR_W-1:OFFSET_W]);
    assign hit_byte  = word_byte(line_data[grant_idx], grant_addr[OFFSET_W-1:0]);

    // Line fill on completion; any flush seen since the grant leaves the new line invalid.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            line_valid <= '0;
            flush_seen <= 1'b0;
        end else begin
            if (accept) flush_seen <= 1'b0;
            if (flush) begin
                line_valid <= '0;
                flush_seen <= 1'b1;
            end
            if (state == WAIT && mem_rdy) begin
                line_data[cur_ch]  <= mem_dout;
                line_tag[cur_ch]   <= mem_addr;
                line_valid[cur_ch] <= !(flush || flush_seen);
            end
        end
    end
`else
    logic unused_flush;

    assign unused_flush = flush;
    assign grant_hit    = 1'b0;
    assign hit_byte     = 8'h00;
`endif

    // State register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = grant_hit ? HIT : ISSUE;
            HIT:     state_nx = IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (mem_rdy) state_nx = DELIVER;
            DELIVER: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs: mem_req falls combinationally with mem_rdy; ch_rdy only from HIT/DELIVER.
    always_comb begin
        ch_rdy  = '0;
        mem_req = 1'b0;
        case (state)
            HIT:     ch_rdy[cur_ch] = 1'b1;
            ISSUE:   mem_req = 1'b1;
            WAIT:    mem_req = !mem_rdy;
            DELIVER: ch_rdy[cur_ch] = deliver_ok;
            default: ;
        endcase
    end

    // Request capture, word address hold and per-channel byte return registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mem_addr   <= '0;
            cur_ch     <= '0;
            cur_off    <= '0;
            ch_data    <= '0;
            drop_seen  <= 1'b0;
            deliver_ok <= 1'b0;
        end else begin
            if (accept) begin
                cur_ch    <= grant_idx;
                cur_off   <= grant_addr[OFFSET_W-1:0];
                drop_seen <= 1'b0;
                if (grant_hit) begin
                    ch_data[int'(grant_idx)*8 +: 8] <= hit_byte;
                end else begin
                    mem_addr <= grant_addr[ADDR_W-1:OFFSET_W];
                end
            end
            if (state == WAIT) begin
                if (!ch_read[cur_ch]) drop_seen <= 1'b1;
                if (mem_rdy) begin
                    deliver_ok <= ch_read[cur_ch] && !drop_seen;
                    if (ch_read[cur_ch] && !drop_seen) begin
                        ch_data[int'(cur_ch)*8 +: 8] <= word_byte(mem_dout, cur_off);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pcm_rom_fetch.sv
// tb/tb_pcm_rom_fetch.sv - directed vector bench for pcm_rom_fetch (cache on or off via PCM_FETCH_CACHE_EN)
`timescale 1ns/1ps
module tb_pcm_rom_fetch;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 18;
`ifdef PCM_FETCH_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic                     clk_sys = 1'b0;
    logic                     reset;
    logic                     flush;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH-1:0]        ch_read;
    logic [NUM_CH*8-1:0]      ch_data;
    logic [NUM_CH-1:0]        ch_rdy;
    logic [ADDR_W-4:0]        mem_addr;
    logic                     mem_req;
    logic                     mem_rdy;
    logic [63:0]              mem_dout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          ch;
        logic [17:0] addr;
        logic [63:0] word;
        bit          hit;
        logic [14:0] maddr;
        logic [7:0]  data;
    } vec_t;

    vec_t vecs [6];

    pcm_rom_fetch #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .flush    (flush),
        .ch_addr  (ch_addr),
        .ch_read  (ch_read),
        .ch_data  (ch_data),
        .ch_rdy   (ch_rdy),
        .mem_addr (mem_addr),
        .mem_req  (mem_req),
        .mem_rdy  (mem_rdy),
        .mem_dout (mem_dout)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        reset   = 1'b1;
        ch_read = '0;
        mem_rdy = 1'b0;
        flush   = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
    endtask

    // Entered at the negedge where the DUT sits in ISSUE; ends at the negedge showing ch_rdy.
    task automatic serve_miss(input int ch, input logic [14:0] maddr, input logic [63:0] word,
                              input logic [7:0] exp_byte, input string name, input bit pflush);
        logic [NUM_CH-1:0] oh;
        oh     = '0;
        oh[ch] = 1'b1;
        check({name, " mem_addr"}, 64'(mem_addr), 64'(maddr));
        check({name, " mem_req"}, 64'(mem_req), 64'd1);
        @(negedge clk_sys);
        if (pflush) begin
            flush = 1'b1;
            @(negedge clk_sys);
            flush = 1'b0;
        end
        check({name, " addr_hold"}, 64'(mem_addr), 64'(maddr));
        mem_rdy  = 1'b1;
        mem_dout = word;
        #1;
        check({name, " req_drop"}, 64'(mem_req), 64'd0);
        @(negedge clk_sys);
        mem_rdy = 1'b0;
        check({name, " ch_rdy"}, 64'(ch_rdy), 64'(oh));
        check({name, " ch_data"}, 64'(ch_data[ch*8 +: 8]), 64'(exp_byte));
        ch_read[ch] = 1'b0;
    endtask

    task automatic read_txn(input int ch, input logic [17:0] addr, input logic [63:0] word, input bit hit,
                            input logic [14:0] maddr, input logic [7:0] exp_byte, input string name);
        logic              exp_hit;
        logic [NUM_CH-1:0] oh;
        exp_hit = CACHE_ON && hit;
        oh      = '0;
        oh[ch]  = 1'b1;
        @(negedge clk_sys);
        ch_addr[ch*ADDR_W +: ADDR_W] = addr;
        ch_read[ch] = 1'b1;
        @(negedge clk_sys);
        check({name, " req_after_grant"}, 64'(mem_req), 64'(!exp_hit));
        check({name, " rdy_after_grant"}, 64'(ch_rdy), exp_hit ? 64'(oh) : 64'd0);
        if (exp_hit) begin
            check({name, " hit_data"}, 64'(ch_data[ch*8 +: 8]), 64'(exp_byte));
            ch_read[ch] = 1'b0;
        end else begin
            serve_miss(ch, maddr, word, exp_byte, name, 1'b0);
        end
    endtask

    initial begin
        vecs[0] = '{0, 18'h00005, 64'h8877665544332211, 1'b0, 15'h0000, 8'h66};
        vecs[1] = '{0, 18'h00007, 64'h8877665544332211, 1'b1, 15'h0000, 8'h88};
        vecs[2] = '{1, 18'h3FFFF, 64'hA1B2C3D4E5F60718, 1'b0, 15'h7FFF, 8'hA1};
        vecs[3] = '{1, 18'h3FFF9, 64'hA1B2C3D4E5F60718, 1'b1, 15'h7FFF, 8'h07};
        vecs[4] = '{1, 18'h00010, 64'h0123456789ABCDEF, 1'b0, 15'h0002, 8'hEF};
        vecs[5] = '{0, 18'h12343, 64'hFEDCBA9876543210, 1'b0, 15'h2468, 8'h76};

        reset    = 1'b1;
        flush    = 1'b0;
        ch_addr  = '0;
        ch_read  = '0;
        mem_rdy  = 1'b0;
        mem_dout = '0;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        check("reset mem_req", 64'(mem_req), 64'd0);
        check("reset mem_addr", 64'(mem_addr), 64'd0);
        check("reset ch_rdy", 64'(ch_rdy), 64'd0);
        check("reset ch_data", 64'(ch_data), 64'd0);

        for (int i = 0; i < 6; i++) begin
            read_txn(vecs[i].ch, vecs[i].addr, vecs[i].word, vecs[i].hit,
                     vecs[i].maddr, vecs[i].data, $sformatf("vec%0d", i));
        end

        // Round robin: simultaneous after reset -> ch0 then ch1.
        do_reset();
        @(negedge clk_sys);
        ch_addr = {18'h00200, 18'h00100};
        ch_read = 2'b11;
        @(negedge clk_sys);
        serve_miss(0, 15'h0020, 64'h00000000000000A0, 8'hA0, "rr1 ch0", 1'b0);
        repeat (2) @(negedge clk_sys);
        serve_miss(1, 15'h0040, 64'h00000000000000B1, 8'hB1, "rr1 ch1", 1'b0);
        // ch0 alone moves priority to ch1, so the next simultaneous pair serves ch1 first.
        read_txn(0, 18'h00300, 64'h00000000000000C2, 1'b0, 15'h0060, 8'hC2, "rr solo ch0");
        @(negedge clk_sys);
        ch_addr = {18'h00500, 18'h00400};
        ch_read = 2'b11;
        @(negedge clk_sys);
        serve_miss(1, 15'h00A0, 64'h00000000000000D3, 8'hD3, "rr2 ch1", 1'b0);
        repeat (2) @(negedge clk_sys);
        serve_miss(0, 15'h0080, 64'h00000000000000E4, 8'hE4, "rr2 ch0", 1'b0);

        // Flush during WAIT: byte still delivered, re-read must miss.
        @(negedge clk_sys);
        ch_addr[0 +: ADDR_W] = 18'h00802;
        ch_read[0] = 1'b1;
        @(negedge clk_sys);
        serve_miss(0, 15'h0100, 64'h0000000000F70000, 8'hF7, "flush fill", 1'b1);
        read_txn(0, 18'h00802, 64'h0000000000F80000, 1'b0, 15'h0100, 8'hF8, "flush reread");

        // Requester drops during WAIT: no ch_rdy, data held, line still filled.
        @(negedge clk_sys);
        ch_addr[0 +: ADDR_W] = 18'h00901;
        ch_read[0] = 1'b1;
        @(negedge clk_sys);
        check("drop issue mem_req", 64'(mem_req), 64'd1);
        @(negedge clk_sys);
        ch_read[0] = 1'b0;
        @(negedge clk_sys);
        mem_rdy  = 1'b1;
        mem_dout = 64'h0000000000005A00;
        @(negedge clk_sys);
        mem_rdy = 1'b0;
        check("drop no ch_rdy", 64'(ch_rdy), 64'd0);
        check("drop data held", 64'(ch_data[7:0]), 64'hF8);
        read_txn(0, 18'h00901, 64'h0000000000005A00, 1'b1, 15'h0120, 8'h5A, "drop reread");

        // Reset in WAIT, then a stale mem_rdy.
        @(negedge clk_sys);
        ch_addr[ADDR_W +: ADDR_W] = 18'h01000;
        ch_read[1] = 1'b1;
        repeat (2) @(negedge clk_sys);
        check("rstwait mem_req", 64'(mem_req), 64'd1);
        reset   = 1'b1;
        ch_read = '0;
        @(negedge clk_sys);
        reset = 1'b0;
        check("rstwait ch_data", 64'(ch_data), 64'd0);
        mem_rdy  = 1'b1;
        mem_dout = 64'hFFFFFFFFFFFFFFFF;
        #1;
        check("stale mem_req", 64'(mem_req), 64'd0);
        @(negedge clk_sys);
        mem_rdy = 1'b0;
        check("stale ch_rdy", 64'(ch_rdy), 64'd0);
        check("stale mem_req2", 64'(mem_req), 64'd0);
        check("stale mem_addr", 64'(mem_addr), 64'd0);
        read_txn(1, 18'h01008, 64'h0000000000000033, 1'b0, 15'h0201, 8'h33, "post reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
